// File: rtl/fetch_unit_if.sv
// Bundle of the fetch unit's program-memory, redirect and decode-handshake signals.
// master = fetch unit side, slave = memory/decode side.
interface fetch_unit_if #(
  parameter int unsigned BIT_WIDTH       = 32,
  parameter int unsigned ADDR_WIDTH      = 32,
  parameter int unsigned IMEM_ADDR_WIDTH = 6,
  parameter int unsigned FIFO_DEPTH      = 4
);
    logic                           redirect;
    logic [ADDR_WIDTH-1:0]          redirect_pc;
    logic [IMEM_ADDR_WIDTH-1:0]     imem_addr;
    logic [BIT_WIDTH-1:0]           imem_q;
    logic                           out_valid;
    logic                           out_ready;
    logic [BIT_WIDTH-1:0]           out_instr;
    logic [ADDR_WIDTH-1:0]          out_pc;
    logic [ADDR_WIDTH-1:0]          out_pc_plus4;
    logic [$clog2(FIFO_DEPTH):0]    fifo_count;

    modport master (
        input  redirect, redirect_pc, imem_q, out_ready,
        output imem_addr, out_valid, out_instr, out_pc, out_pc_plus4, fifo_count
    );

    modport slave (
        output redirect, redirect_pc, imem_q, out_ready,
        input  imem_addr, out_valid, out_instr, out_pc, out_pc_plus4, fifo_count
    );
endinterface

// File: rtl/fetch_unit.sv
// Instruction-fetch front end: owns the fetch PC, drives a one-cycle-latency
// program memory and buffers fetched words in a prefetch queue towards decode.
module fetch_unit #(
    parameter int unsigned          BIT_WIDTH       = 32,
    parameter int unsigned          ADDR_WIDTH      = 32,
    parameter int unsigned          IMEM_ADDR_WIDTH = 6,
    parameter int unsigned          FIFO_DEPTH      = 4,
    parameter logic [ADDR_WIDTH-1:0] RESET_PC       = '0
) (
    input  logic        clk,
    input  logic        rst,
    fetch_unit_if.master bus
);
    localparam int unsigned PW = $clog2(FIFO_DEPTH);
    localparam int unsigned CW = PW + 1;

    logic [ADDR_WIDTH-1:0] fpc_q, fpc_d;
    logic                  req_v_q, req_v_d;
    logic [ADDR_WIDTH-1:0] req_pc_q, req_pc_d;
    logic [PW-1:0]         rd_q, rd_d, wr_q, wr_d;
    logic [CW-1:0]         count_q, count_d;

    logic [BIT_WIDTH-1:0]  instr_mem [FIFO_DEPTH];
    logic [ADDR_WIDTH-1:0] pc_mem    [FIFO_DEPTH];

    logic                  out_valid;
    logic                  pop, push, issue;
    logic [CW:0]           credit;

    assign out_valid = (count_q != '0);
    assign pop       = out_valid && bus.out_ready;
    assign push      = req_v_q && !bus.redirect;
    // Credit counts the in-flight word so a pending response always has a slot.
    assign credit    = {1'b0, count_q} - (CW+1)'(pop) + (CW+1)'(req_v_q);
    assign issue     = !bus.redirect && (credit < (CW+1)'(FIFO_DEPTH));

    always_comb begin
        fpc_d    = fpc_q;
        req_v_d  = issue;
        req_pc_d = req_pc_q;
        rd_d     = rd_q;
        wr_d     = wr_q;
        count_d  = count_q;
        if (bus.redirect) begin
            fpc_d   = bus.redirect_pc & ~ADDR_WIDTH'(3);
            req_v_d = 1'b0;
            rd_d    = '0;
            wr_d    = '0;
            count_d = '0;
        end else begin
            if (issue) begin
                req_pc_d = fpc_q;
                fpc_d    = fpc_q + ADDR_WIDTH'(4);
            end
            if (push) wr_d = wr_q + PW'(1);
            if (pop)  rd_d = rd_q + PW'(1);
            count_d = count_q + CW'(push) - CW'(pop);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            fpc_q    <= RESET_PC;
            req_v_q  <= 1'b0;
            req_pc_q <= '0;
            rd_q     <= '0;
            wr_q     <= '0;
            count_q  <= '0;
        end else begin
            fpc_q    <= fpc_d;
            req_v_q  <= req_v_d;
            req_pc_q <= req_pc_d;
            rd_q     <= rd_d;
            wr_q     <= wr_d;
            count_q  <= count_d;
        end
    end

    // Payload storage needs no reset: entries are only visible while counted.
    always_ff @(posedge clk) begin
        if (push) begin
            instr_mem[wr_q] <= bus.imem_q;
            pc_mem[wr_q]    <= req_pc_q;
        end
    end

    assign bus.imem_addr    = fpc_q[IMEM_ADDR_WIDTH+1:2];
    assign bus.out_valid    = out_valid;
    assign bus.out_instr    = out_valid ? instr_mem[rd_q] : '0;
    assign bus.out_pc       = out_valid ? pc_mem[rd_q] : '0;
    assign bus.out_pc_plus4 = out_valid ? pc_mem[rd_q] + ADDR_WIDTH'(4) : '0;
    assign bus.fifo_count   = count_q;

    a_no_overflow: assert property (@(posedge clk) disable iff (!rst)
        !(push && (count_q == CW'(FIFO_DEPTH)) && !pop))
        else $error("fetch_unit: push into full prefetch queue");

endmodule

// File: tb/tb_fetch_unit.sv
// Randomized self-checking bench for fetch_unit against a queue-based reference
// model, with a few literal checks pinning startup, backpressure and redirects.
module tb_fetch_unit;
    localparam int unsigned DEPTH = 4;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    fetch_unit_if #(.BIT_WIDTH(32), .ADDR_WIDTH(32), .IMEM_ADDR_WIDTH(6),
                    .FIFO_DEPTH(DEPTH)) bus ();

    fetch_unit #(.BIT_WIDTH(32), .ADDR_WIDTH(32), .IMEM_ADDR_WIDTH(6),
                 .FIFO_DEPTH(DEPTH), .RESET_PC(32'h0)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.master)
    );

    // Synchronous program memory: word n = 0x1000_0000 + n.
    logic [31:0] mem [64];
    initial for (int i = 0; i < 64; i++) mem[i] = 32'h1000_0000 + i;
    always @(posedge clk) bus.imem_q <= mem[bus.imem_addr];

    int n_checks = 0;
    int n_pass   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    endtask

    // Reference model: a queue of fetched PCs, one in-flight slot and the fetch PC.
    logic [31:0] m_q[$];
    bit          m_inf_v;
    logic [31:0] m_inf_pc;
    logic [31:0] m_fpc;

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            m_q.delete();
            m_inf_v = 0;
            m_fpc   = 32'h0;
        end else begin
            automatic bit m_pop = (m_q.size() != 0) && bus.out_ready;
            if (bus.redirect) begin
                m_q.delete();
                m_inf_v = 0;
                m_fpc   = {bus.redirect_pc[31:2], 2'b00};
            end else begin
                automatic bit m_issue = (int'(m_q.size()) - int'(m_pop) + int'(m_inf_v)) < DEPTH;
                if (m_pop)   void'(m_q.pop_front());
                if (m_inf_v) m_q.push_back(m_inf_pc);
                m_inf_v = m_issue;
                if (m_issue) begin
                    m_inf_pc = m_fpc;
                    m_fpc    = m_fpc + 32'd4;
                end
            end
        end
    end

    always @(negedge clk) begin
        if (rst) begin
            automatic bit          v  = (m_q.size() != 0);
            automatic logic [31:0] pc = v ? m_q[0] : 32'h0;
            chk("out_valid",    {31'b0, bus.out_valid}, {31'b0, v});
            chk("fifo_count",   {29'b0, bus.fifo_count}, m_q.size());
            chk("out_pc",       bus.out_pc, pc);
            chk("out_instr",    bus.out_instr, v ? mem[pc[7:2]] : 32'h0);
            chk("out_pc_plus4", bus.out_pc_plus4, v ? pc + 32'd4 : 32'h0);
            chk("imem_addr",    {26'b0, bus.imem_addr}, {26'b0, m_fpc[7:2]});
        end
    end

    task automatic step(input int n = 1);
        repeat (n) begin
            @(negedge clk);
            #1;
        end
    endtask

    initial begin
        bus.redirect    = 1'b0;
        bus.redirect_pc = '0;
        bus.out_ready   = 1'b1;
        #2;
        chk("rst_valid",  {31'b0, bus.out_valid}, 32'h0);
        chk("rst_count",  {29'b0, bus.fifo_count}, 32'h0);
        chk("rst_imem",   {26'b0, bus.imem_addr}, 32'h0);
        chk("rst_pc",     bus.out_pc, 32'h0);
        step(2);
        rst = 1'b1;

        // Startup: valid low after E0, head = PC 0 after E1, then 4, 8.
        step();
        chk("start_e0_valid", {31'b0, bus.out_valid}, 32'h0);
        step();
        chk("start_e1_valid", {31'b0, bus.out_valid}, 32'h1);
        chk("start_e1_pc",    bus.out_pc, 32'h0);
        chk("start_e1_instr", bus.out_instr, 32'h1000_0000);
        step();
        chk("start_e2_pc",    bus.out_pc, 32'h4);
        step();
        chk("start_e3_pc",    bus.out_pc, 32'h8);
        step(6);

        // Backpressure fills the queue to DEPTH.
        bus.out_ready = 1'b0;
        step(10);
        chk("bp_full", {29'b0, bus.fifo_count}, DEPTH);
        bus.out_ready = 1'b1;
        step(8);

        // Redirect to 0x40 with count=3 and a request in flight.
        bus.out_ready = 1'b0;
        step(8);
        bus.out_ready = 1'b1;
        step();
        chk("rd1_count3", {29'b0, bus.fifo_count}, 32'd3);
        bus.out_ready   = 1'b0;
        bus.redirect    = 1'b1;
        bus.redirect_pc = 32'h40;
        step();
        bus.redirect = 1'b0;
        chk("rd1_r0_valid", {31'b0, bus.out_valid}, 32'h0);
        step();
        chk("rd1_r1_valid", {31'b0, bus.out_valid}, 32'h0);
        step();
        chk("rd1_r2_pc", bus.out_pc, 32'h40);
        bus.out_ready = 1'b1;
        step();
        chk("rd1_r3_pc", bus.out_pc, 32'h44);
        step(4);

        // Redirect on a full queue with a coincident pop.
        bus.out_ready = 1'b0;
        step(8);
        bus.out_ready   = 1'b1;
        bus.redirect    = 1'b1;
        bus.redirect_pc = 32'h80;
        step();
        bus.redirect = 1'b0;
        chk("rd2_r0_valid", {31'b0, bus.out_valid}, 32'h0);
        step(2);
        chk("rd2_r2_pc", bus.out_pc, 32'h80);
        step(4);

        // Redirect to the top of the address space; low bits of target ignored.
        bus.out_ready   = 1'b0;
        bus.redirect    = 1'b1;
        bus.redirect_pc = 32'hFFFF_FFFE;
        step();
        bus.redirect = 1'b0;
        step(2);
        chk("wrap_pc",    bus.out_pc, 32'hFFFF_FFFC);
        chk("wrap_pc4",   bus.out_pc_plus4, 32'h0);
        chk("wrap_instr", bus.out_instr, 32'h1000_003F);
        bus.out_ready = 1'b1;
        step();
        chk("wrap_next_pc", bus.out_pc, 32'h0);

        // Randomized traffic.
        for (int i = 0; i < 2000; i++) begin
            bus.out_ready   = ($urandom_range(0, 3) != 0);
            bus.redirect    = ($urandom_range(0, 19) == 0);
            bus.redirect_pc = $urandom;
            step();
        end
        bus.redirect = 1'b0;

        // Asynchronous reset between edges.
        bus.out_ready = 1'b0;
        step(6);
        rst = 1'b0;
        #1;
        chk("arst_valid", {31'b0, bus.out_valid}, 32'h0);
        chk("arst_count", {29'b0, bus.fifo_count}, 32'h0);
        chk("arst_imem",  {26'b0, bus.imem_addr}, 32'h0);
        step(2);
        bus.out_ready = 1'b1;
        rst = 1'b1;
        step();
        chk("arst_e0_valid", {31'b0, bus.out_valid}, 32'h0);
        step();
        chk("arst_e1_pc",    bus.out_pc, 32'h0);
        chk("arst_e1_instr", bus.out_instr, 32'h1000_0000);
        step();
        chk("arst_e2_pc",    bus.out_pc, 32'h4);

        for (int i = 0; i < 500; i++) begin
            bus.out_ready = $urandom_range(0, 1) == 1;
            step();
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
